pl_io_responder: RTL and testbench
==================================

PL_IO_RESPONDER -- requirements
Module: pl_io_responder

Interface
REQ-001 Parameter SYNC_STAGES, default 2, SHALL set the synchroniser depth on each input port (legal range 2..4).
REQ-002 Parameter SEL_MASK, default 32'hFFFF_FF00, SHALL select which address bits decode the I/O page.
REQ-003 Parameter SEL_BASE, default 32'h0000_0000, SHALL give the I/O page base address, compared under SEL_MASK.
REQ-004 clock  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 addr  in  32  CPU MEM-stage byte address.
REQ-007 datain  in  32  CPU store data.
REQ-008 we  in  1  store strobe (wmem), valid for one cycle.
REQ-009 re  in  1  load strobe, valid for one cycle.
REQ-010 dataout  out  32  registered read data.
REQ-011 rvalid  out  1  high for exactly one cycle when dataout holds a response.
REQ-012 in_port0, in_port1  in  32 each  asynchronous external inputs.
REQ-013 out_port0, out_port1  out  32 each  registered external outputs.
REQ-014 irq  out  1  high while any enabled status flag is set.

Function
REQ-015 Block SHALL be selected when (addr & SEL_MASK) == SEL_BASE; register offset SHALL be addr[7:2]; addr[1:0] SHALL be ignored.
REQ-016 Map: 0x80 OUT0 RW; 0x84 OUT1 RW; 0xC0 IN0 RO; 0xC4 IN1 RO; 0xC8 STATUS (bit0 IN0 changed, bit1 IN1 changed, W1C); 0xCC IRQEN RW, bits[1:0]; 0xD0 CYCLES RO; all other offsets SHALL read 0, and writes to them SHALL be ignored.
REQ-017 Store: when selected and we=1, the target register SHALL take datain at that edge; out_port0/out_port1 SHALL show the new value from the next cycle.
REQ-018 Load: when selected and re=1 in cycle N, dataout SHALL carry the register value as sampled at edge N and rvalid SHALL be 1 in cycle N+1; otherwise rvalid=0 and dataout SHALL hold its last value.
REQ-019 If we and re are both high in the same cycle, the write SHALL take effect and the read SHALL return the pre-write value.
REQ-020 Each in_port SHALL pass through SYNC_STAGES flops, then a sample register; IN0/IN1 reads SHALL return the sample register.
REQ-021 When the sample register value differs from the previous sample, the corresponding STATUS bit SHALL set on the following edge.
REQ-022 STATUS writes: a 1 in bit k SHALL clear bit k; a set event in the same cycle as a clear SHALL win, leaving the bit set.
REQ-023 irq SHALL equal |(STATUS[1:0] & IRQEN[1:0]), registered (one-cycle delay after a STATUS/IRQEN change).
REQ-024 CYCLES SHALL increment by 1 every cycle, wrapping 32'hFFFF_FFFF -> 0; writes SHALL be ignored.
REQ-025 Unselected accesses SHALL not alter any state and SHALL not raise rvalid.

Reset
REQ-026 While resetn=0: out_port0, out_port1, dataout, STATUS, IRQEN, CYCLES, synchroniser and sample flops SHALL all be 0; rvalid=0; irq=0.
REQ-027 Reset asserted mid-access SHALL abort that access with no rvalid pulse; after release, the first edge SHALL be treated as idle.
REQ-028 The first post-reset sample differing from 0 SHALL set its STATUS bit (no spurious-change suppression).

Structure
REQ-029 Register offsets, STATUS bit positions and the default SEL_MASK/SEL_BASE SHALL live in shared package pl_io_pkg.
REQ-030 The synchroniser plus change detector SHALL be the sub-module pl_io_sync (parameters SYNC_STAGES, width 32), instantiated twice.

Verification
REQ-031 Reset, then we at 0x80 with data 32'h0000_00A5 -> out_port0 = 32'h0000_00A5 from the next cycle; out_port1 remains 0.
REQ-032 re at 0x84 after OUT1 has been written 32'hDEAD_BEEF -> rvalid for exactly one cycle, one cycle later, with dataout = 32'hDEAD_BEEF.
REQ-033 in_port0 driven to 32'h1234 -> IN0 reads 32'h1234 after SYNC_STAGES+1 edges; STATUS bit0 = 1; with IRQEN = 1, irq = 1 one cycle later.
REQ-034 Write STATUS = 1 in the same cycle that in_port0 produces a new sample change -> bit0 stays 1; a W1C write in a quiet cycle clears it and drops irq.
REQ-035 Same-cycle we and re to 0x80 (old value 5, new value 9) -> dataout = 5, and out_port0 = 9 afterwards.
REQ-036 Pulse resetn low in the cycle after re -> no rvalid pulse, all outputs 0, and CYCLES restarts from 0 and wraps correctly when preloaded by force to 32'hFFFF_FFFF.

Source files
------------

// File: rtl/pl_io_pkg.sv
// Shared register map, STATUS bit positions and default page decode for the
// memory-mapped I/O responder.
package pl_io_pkg;

  localparam logic [31:0] SEL_MASK_DEF = 32'hFFFF_FF00;
  localparam logic [31:0] SEL_BASE_DEF = 32'h0000_0000;

  // Word offsets (addr[7:2]) of the mapped registers
  localparam logic [5:0] OFF_OUT0   = 6'h20;  // 0x80
  localparam logic [5:0] OFF_OUT1   = 6'h21;  // 0x84
  localparam logic [5:0] OFF_IN0    = 6'h30;  // 0xC0
  localparam logic [5:0] OFF_IN1    = 6'h31;  // 0xC4
  localparam logic [5:0] OFF_STATUS = 6'h32;  // 0xC8
  localparam logic [5:0] OFF_IRQEN  = 6'h33;  // 0xCC
  localparam logic [5:0] OFF_CYCLES = 6'h34;  // 0xD0

  localparam int ST_IN0 = 0;
  localparam int ST_IN1 = 1;

endpackage

// File: rtl/pl_io_sync.sv
// Multi-flop synchroniser for an asynchronous input bus, followed by a sample
// register and a change flag comparing the sample against its previous value.
module pl_io_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int WIDTH       = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] port,
  output logic [WIDTH-1:0] sample,
  output logic             changed
);

  logic [WIDTH-1:0] sync_p [SYNC_STAGES];
  logic [WIDTH-1:0] prev;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
      sample <= '0;
      prev   <= '0;
    end else begin
      sync_p[0] <= port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
      sample <= sync_p[SYNC_STAGES-1];
      prev   <= sample;
    end
  end

  // A fresh sample differs from its predecessor for exactly one cycle
  assign changed = (sample != prev);

endmodule

// File: rtl/pl_io_responder.sv
// Memory-mapped I/O page on the CPU MEM stage: two output registers, two
// synchronised input ports with change flags, interrupt enable and a free-running cycle counter.
module pl_io_responder
  import pl_io_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] SEL_MASK    = SEL_MASK_DEF,
  parameter logic [31:0] SEL_BASE    = SEL_BASE_DEF
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] addr,
  input  logic [31:0] datain,
  input  logic        we,
  input  logic        re,
  output logic [31:0] dataout,
  output logic        rvalid,
  input  logic [31:0] in_port0,
  input  logic [31:0] in_port1,
  output logic [31:0] out_port0,
  output logic [31:0] out_port1,
  output logic        irq
);

  logic        sel;
  logic [5:0]  off;
  logic        wr;
  logic        rd;
  logic [31:0] in0_sample;
  logic [31:0] in1_sample;
  logic        in0_chg;
  logic        in1_chg;
  logic [1:0]  status;
  logic [1:0]  irqen;
  logic [31:0] cycles;
  logic [31:0] rdata;
  logic [1:0]  status_set;
  logic [1:0]  status_clr;
  logic [1:0]  status_next;

  assign sel = ((addr & SEL_MASK) == SEL_BASE);
  assign off = addr[7:2];
  assign wr  = sel & we;
  assign rd  = sel & re;

  pl_io_sync #(.SYNC_STAGES(SYNC_STAGES), .WIDTH(32)) u_sync0 (
    .clock   (clock),
    .resetn  (resetn),
    .port    (in_port0),
    .sample  (in0_sample),
    .changed (in0_chg)
  );

  pl_io_sync #(.SYNC_STAGES(SYNC_STAGES), .WIDTH(32)) u_sync1 (
    .clock   (clock),
    .resetn  (resetn),
    .port    (in_port1),
    .sample  (in1_sample),
    .changed (in1_chg)
  );

  // Read mux sees pre-edge state, so a same-cycle write returns the old value
  always_comb begin
    rdata = '0;
    case (off)
      OFF_OUT0:   rdata = out_port0;
      OFF_OUT1:   rdata = out_port1;
      OFF_IN0:    rdata = in0_sample;
      OFF_IN1:    rdata = in1_sample;
      OFF_STATUS: rdata = {30'd0, status};
      OFF_IRQEN:  rdata = {30'd0, irqen};
      OFF_CYCLES: rdata = cycles;
      default:    rdata = '0;
    endcase
  end

  // Set events are OR-ed in after the W1C mask so a coincident set survives
  always_comb begin
    status_set         = '0;
    status_set[ST_IN0] = in0_chg;
    status_set[ST_IN1] = in1_chg;
    status_clr         = (wr && off == OFF_STATUS) ? datain[1:0] : 2'b00;
    status_next        = (status & ~status_clr) | status_set;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_port0 <= '0;
      out_port1 <= '0;
      status    <= '0;
      irqen     <= '0;
      cycles    <= '0;
      irq       <= 1'b0;
      rvalid    <= 1'b0;
      dataout   <= '0;
    end else begin
      if (wr && off == OFF_OUT0)  out_port0 <= datain;
      if (wr && off == OFF_OUT1)  out_port1 <= datain;
      if (wr && off == OFF_IRQEN) irqen     <= datain[1:0];
      status <= status_next;
      irq    <= |(status & irqen);
      cycles <= cycles + 32'd1;
      rvalid <= rd;
      if (rd) dataout <= rdata;
    end
  end

endmodule

// File: tb/tb_pl_io_responder.sv
// Scoreboard bench for pl_io_responder: a behavioural model predicts register
// contents and read responses; a monitor compares DUT outputs on the falling edge.
module tb_pl_io_responder;

  localparam int S = 2;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] datain = '0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [31:0] in_port0 = '0;
  logic [31:0] in_port1 = '0;
  logic [31:0] dataout;
  logic        rvalid;
  logic [31:0] out_port0;
  logic [31:0] out_port1;
  logic        irq;

  pl_io_responder #(.SYNC_STAGES(S)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .addr      (addr),
    .datain    (datain),
    .we        (we),
    .re        (re),
    .dataout   (dataout),
    .rvalid    (rvalid),
    .in_port0  (in_port0),
    .in_port1  (in_port1),
    .out_port0 (out_port0),
    .out_port1 (out_port1),
    .irq       (irq)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_out0, m_out1, m_cycles, m_dataout;
  logic [1:0]  m_status, m_irqen;
  logic        m_irq;
  logic [31:0] m_samp0, m_samp1, m_prev0, m_prev1;
  logic [31:0] m_dl0[$];
  logic [31:0] m_dl1[$];
  logic [31:0] exp_q[$];

  task automatic m_reset();
    m_out0 = '0; m_out1 = '0; m_cycles = '0; m_dataout = '0;
    m_status = '0; m_irqen = '0; m_irq = 1'b0;
    m_samp0 = '0; m_samp1 = '0; m_prev0 = '0; m_prev1 = '0;
    m_dl0.delete(); m_dl1.delete();
    for (int i = 0; i < S; i++) begin
      m_dl0.push_back('0);
      m_dl1.push_back('0);
    end
    exp_q.delete();
  endtask

  function automatic logic [31:0] m_read(input logic [7:0] ba);
    case (ba)
      8'h80:   return m_out0;
      8'h84:   return m_out1;
      8'hC0:   return m_samp0;
      8'hC4:   return m_samp1;
      8'hC8:   return {30'd0, m_status};
      8'hCC:   return {30'd0, m_irqen};
      8'hD0:   return m_cycles;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clock or negedge resetn) begin : model
    logic [31:0] rv;
    logic        selv;
    logic [7:0]  ba;
    logic [1:0]  setv;
    logic [1:0]  clrv;
    if (!resetn) begin
      m_reset();
    end else begin
      selv = ((addr & 32'hFFFF_FF00) == 32'h0000_0000);
      ba   = addr[7:0] & 8'hFC;
      setv = {m_samp1 != m_prev1, m_samp0 != m_prev0};
      clrv = (selv && we && ba == 8'hC8) ? datain[1:0] : 2'b00;
      if (selv && re) begin
        rv = m_read(ba);
        exp_q.push_back(rv);
        m_dataout = rv;
      end
      m_irq    = |(m_status & m_irqen);
      m_status = (m_status & ~clrv) | setv;
      if (selv && we) begin
        case (ba)
          8'h80:   m_out0  = datain;
          8'h84:   m_out1  = datain;
          8'hCC:   m_irqen = datain[1:0];
          default: ;
        endcase
      end
      m_cycles = m_cycles + 32'd1;
      m_prev0  = m_samp0;
      m_prev1  = m_samp1;
      m_dl0.push_back(in_port0);
      m_dl1.push_back(in_port1);
      m_samp0 = m_dl0.pop_front();
      m_samp1 = m_dl1.pop_front();
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    logic [31:0] e;
    chk("rvalid", {31'd0, rvalid}, {31'd0, exp_q.size() != 0});
    if (rvalid && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("read_data", dataout, e);
    end
    exp_q.delete();
    chk("dataout", dataout, m_dataout);
    chk("out_port0", out_port0, m_out0);
    chk("out_port1", out_port1, m_out1);
    chk("irq", {31'd0, irq}, {31'd0, m_irq});
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
    addr = a; datain = d; we = w; re = r;
    @(posedge clock); #2;
    we = 1'b0; re = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] offs [8];
    offs = '{32'h80, 32'h84, 32'hC0, 32'hC4, 32'hC8, 32'hCC, 32'hD0, 32'h40};

    repeat (2) @(posedge clock);
    #2;
    chk("reset_out0", out_port0, 32'h0);
    chk("reset_out1", out_port1, 32'h0);
    chk("reset_rvalid", {31'd0, rvalid}, 32'h0);
    chk("reset_irq", {31'd0, irq}, 32'h0);
    resetn = 1'b1;
    idle(1);

    cyc(32'h80, 32'h0000_00A5, 1'b1, 1'b0);
    chk("out0_a5", out_port0, 32'h0000_00A5);
    chk("out1_still0", out_port1, 32'h0);

    cyc(32'h84, 32'hDEAD_BEEF, 1'b1, 1'b0);
    cyc(32'h84, 32'h0, 1'b0, 1'b1);
    chk("rd_out1_valid", {31'd0, rvalid}, 32'h1);
    chk("rd_out1_data", dataout, 32'hDEAD_BEEF);
    idle(1);
    chk("rd_out1_once", {31'd0, rvalid}, 32'h0);

    cyc(32'hCC, 32'h1, 1'b1, 1'b0);
    in_port0 = 32'h1234;
    idle(S + 1);
    cyc(32'hC0, 32'h0, 1'b0, 1'b1);
    chk("in0_read", dataout, 32'h1234);
    cyc(32'hC8, 32'h0, 1'b0, 1'b1);
    chk("status_set", dataout, 32'h1);
    chk("irq_set", {31'd0, irq}, 32'h1);

    cyc(32'hC8, 32'h1, 1'b1, 1'b0);
    idle(1);
    chk("irq_cleared", {31'd0, irq}, 32'h0);

    in_port0 = 32'h5678;
    idle(S + 1);
    cyc(32'hC8, 32'h1, 1'b1, 1'b0);
    cyc(32'hC8, 32'h0, 1'b0, 1'b1);
    chk("set_wins", dataout, 32'h1);
    cyc(32'hC8, 32'h1, 1'b1, 1'b0);
    idle(1);
    chk("irq_drop_quiet", {31'd0, irq}, 32'h0);
    cyc(32'hC8, 32'h0, 1'b0, 1'b1);
    chk("status_clear", dataout, 32'h0);

    cyc(32'h80, 32'd5, 1'b1, 1'b0);
    cyc(32'h80, 32'd9, 1'b1, 1'b1);
    chk("rw_old_data", dataout, 32'd5);
    chk("rw_new_out0", out_port0, 32'd9);

    addr = 32'h84; re = 1'b1;
    #1 resetn = 1'b0;
    @(posedge clock); #2;
    re = 1'b0;
    chk("abort_rvalid", {31'd0, rvalid}, 32'h0);
    chk("abort_dataout", dataout, 32'h0);
    chk("abort_out0", out_port0, 32'h0);
    resetn = 1'b1;
    idle(1);
    cyc(32'hD0, 32'h0, 1'b0, 1'b1);
    chk("cycles_restart", dataout, 32'd1);

    force dut.cycles = 32'hFFFF_FFFF;
    m_cycles = 32'hFFFF_FFFF;
    #1 release dut.cycles;
    cyc(32'hD0, 32'h0, 1'b0, 1'b1);
    chk("cycles_max", dataout, 32'hFFFF_FFFF);
    cyc(32'hD0, 32'h0, 1'b0, 1'b1);
    chk("cycles_wrap", dataout, 32'h0);

    for (int i = 0; i < 600; i++) begin
      a = offs[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a | ($urandom & 32'hFFFF_FF00);
      if ($urandom_range(0, 9) == 0) in_port0 = $urandom;
      if ($urandom_range(0, 11) == 0) in_port1 = in_port1 ^ (32'h1 << $urandom_range(0, 31));
      if (i % 200 == 199) begin
        resetn = 1'b0;
        idle(1);
        resetn = 1'b1;
      end
      cyc(a, $urandom, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0);
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
